// File: rtl/qint_sched.sv
// qint_sched: shares one QBUS interrupt slot among NSRC internal sources.
// Level then round-robin arbitration, IAKI/IAKO chain, DIN/RPLY vector cycle.
module qint_sched #(
    parameter int NSRC  = 4,
    parameter int VEC_W = 9
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NSRC-1:0]       src_req,
    input  logic [NSRC-1:0]       src_clr,
    input  logic [2*NSRC-1:0]     src_level,
    input  logic [VEC_W*NSRC-1:0] src_vector,
    output logic [NSRC-1:0]       src_ack,
    input  logic                  RINIT,
    input  logic                  RDIN,
    input  logic [4:7]            RIRQ,
    input  logic                  RIAKI,
    output logic [4:7]            TIRQ,
    output logic                  TIAKO,
    output logic                  TRPLY,
    output logic [VEC_W-1:0]      vector_out,
    output logic                  vector_en
);

    localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_VECTOR,
        S_REPLY,
        S_WAIT
    } state_t;

    state_t           r_state;
    logic [NSRC-1:0]  r_pend;
    logic [NSRC-1:0]  r_ack;
    logic             r_rdin_q;
    logic             r_trply;
    logic             r_ven;
    logic [IW-1:0]    r_rr;
    logic [IW-1:0]    r_grant;
    logic [VEC_W-1:0] r_vec;
    logic [4:7]       r_tirq;

    logic             w_clr;
    logic             w_rise;
    logic             w_fall;
    logic             w_any;
    logic             w_found;
    logic             w_blk;
    logic             w_excl;
    logic [1:0]       w_maxlvl;
    logic [1:0]       w_winlvl;
    logic [IW-1:0]    w_win;
    logic [4:7]       w_tirq;

    function automatic int rot(input logic [IW-1:0] base, input int k);
        return (int'(base) + k) % NSRC;
    endfunction

    assign w_clr  = ~reset_n | RINIT;
    assign w_rise = RDIN & ~r_rdin_q;
    assign w_fall = ~RDIN & r_rdin_q;
    assign w_excl = (r_state == S_VECTOR) || (r_state == S_REPLY) ||
                    (r_state == S_WAIT);

    // highest level present among pending sources
    always_comb begin
        w_any    = 1'b0;
        w_maxlvl = 2'd0;
        for (int i = 0; i < NSRC; i++) begin
            if (r_pend[i]) begin
                w_any = 1'b1;
                if (src_level[2*i +: 2] > w_maxlvl)
                    w_maxlvl = src_level[2*i +: 2];
            end
        end
    end

    // first source at that level, scanning upward from the rr pointer
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (!w_found && r_pend[rot(r_rr, k)] &&
                src_level[2*rot(r_rr, k) +: 2] == w_maxlvl) begin
                w_found = 1'b1;
                w_win   = IW'(rot(r_rr, k));
            end
        end
    end

    // winner loses to any external request strictly above its level
    always_comb begin
        w_winlvl = src_level[2*int'(w_win) +: 2];
        unique case (w_winlvl)
            2'd0:    w_blk = RIRQ[5] | RIRQ[6];
            2'd1:    w_blk = RIRQ[6];
            2'd2:    w_blk = RIRQ[7];
            default: w_blk = 1'b0;
        endcase
    end

    // IRQ lines requested by pending sources, minus the one being serviced
    always_comb begin
        w_tirq = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (r_pend[i] && !(w_excl && r_grant == IW'(i))) begin
                w_tirq[4] = 1'b1;
                case (src_level[2*i +: 2])
                    2'd1: w_tirq[5] = 1'b1;
                    2'd2: w_tirq[6] = 1'b1;
                    2'd3: begin
                        w_tirq[6] = 1'b1;
                        w_tirq[7] = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // DIN edge history; bus init deliberately leaves it alone
    always_ff @(posedge clk) begin
        if (!reset_n) r_rdin_q <= 1'b0;
        else          r_rdin_q <= RDIN;
    end

    // pending latches: clears beat a same-cycle request
    always_ff @(posedge clk) begin
        if (w_clr) r_pend <= '0;
        else       r_pend <= (r_pend | src_req) & ~src_clr & ~r_ack;
    end

    // registered IRQ drive
    always_ff @(posedge clk) begin
        if (w_clr) r_tirq <= '0;
        else       r_tirq <= w_tirq;
    end

    // grant / vector handshake sequencer with registered outputs
    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_state <= S_IDLE;
            r_trply <= 1'b0;
            r_ven   <= 1'b0;
            r_ack   <= '0;
            r_rr    <= '0;
            r_grant <= '0;
            r_vec   <= '0;
        end else begin
            r_ack <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_rise && w_any && !w_blk) begin
                        r_grant <= w_win;
                        r_vec   <= src_vector[VEC_W*int'(w_win) +: VEC_W];
                        r_state <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (RIAKI) begin
                        r_ven   <= 1'b1;
                        r_state <= S_VECTOR;
                    end else if (w_fall) begin
                        r_state <= S_IDLE;
                    end
                end
                S_VECTOR: begin
                    r_trply <= 1'b1;
                    r_state <= S_REPLY;
                end
                S_REPLY: begin
                    if (w_fall) begin
                        r_trply <= 1'b0;
                        r_ven   <= 1'b0;
                        r_ack   <= NSRC'(1) << r_grant;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_rr    <= (r_grant == IW'(NSRC-1)) ? '0 : r_grant + 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign TIAKO      = RIAKI & (r_state == S_IDLE);
    assign TIRQ       = r_tirq;
    assign TRPLY      = r_trply;
    assign vector_en  = r_ven;
    assign vector_out = r_vec;
    assign src_ack    = r_ack;

endmodule

// File: tb/tb_qint_sched.sv
// tb_qint_sched: directed stimulus for qint_sched, checked every cycle
// against a transaction-level model plus hand-computed expectations.
module tb_qint_sched;

    localparam int NSRC = 4;
    localparam int P_IDLE = 0, P_ARMED = 1, P_VECTOR = 2, P_REPLY = 3, P_WAIT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, rinit, rdin, riaki;
    logic [3:0] req, clr;
    logic [4:7] rirq;
    int         lvl [NSRC];
    logic [8:0] vecs [NSRC];
    logic [7:0] lvl_bus;
    logic [35:0] vec_bus;

    logic [3:0] ack;
    logic [4:7] tirq;
    logic       tiako, trply, ven;
    logic [8:0] vout;

    int checks = 0;
    int failures = 0;
    int served[$];

    always_comb begin
        lvl_bus = '0;
        vec_bus = '0;
        for (int i = 0; i < NSRC; i++) begin
            lvl_bus[2*i +: 2] = 2'(lvl[i] - 4);
            vec_bus[9*i +: 9] = vecs[i];
        end
    end

    qint_sched #(.NSRC(4), .VEC_W(9)) dut (
        .clk(clk), .reset_n(rst_n),
        .src_req(req), .src_clr(clr),
        .src_level(lvl_bus), .src_vector(vec_bus),
        .src_ack(ack),
        .RINIT(rinit), .RDIN(rdin), .RIRQ(rirq), .RIAKI(riaki),
        .TIRQ(tirq), .TIAKO(tiako), .TRPLY(trply),
        .vector_out(vout), .vector_en(ven)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_phase = P_IDLE;
    int         m_grant = 0;
    int         m_rr = 0;
    bit         m_pend [NSRC];
    bit         m_rdq = 1'b0;
    logic [4:7] m_tirq = '0;
    logic [8:0] m_vec = '0;

    function automatic int pick();
        int best = -1;
        int bl = 0;
        for (int k = 0; k < NSRC; k++) begin
            int i;
            i = (m_rr + k) % NSRC;
            if (m_pend[i] && lvl[i] > bl) begin
                bl = lvl[i];
                best = i;
            end
        end
        return best;
    endfunction

    function automatic bit blocked(input int l);
        return (l == 4 && (rirq[5] || rirq[6])) ||
               (l == 5 && rirq[6]) || (l == 6 && rirq[7]);
    endfunction

    task automatic model_step();
        bit rise, fall, excl;
        int w;
        logic [4:7] t;
        bit np [NSRC];
        rise = rdin && !m_rdq;
        fall = !rdin && m_rdq;
        m_rdq = rst_n ? rdin : 1'b0;
        if (!rst_n || rinit) begin
            for (int i = 0; i < NSRC; i++) m_pend[i] = 0;
            m_phase = P_IDLE;
            m_tirq = '0;
            m_rr = 0;
            m_grant = 0;
            m_vec = '0;
        end else begin
            excl = m_phase >= P_VECTOR;
            t = '0;
            for (int i = 0; i < NSRC; i++) begin
                if (m_pend[i] && !(excl && m_grant == i)) begin
                    t[4] = 1;
                    if (lvl[i] == 5) t[5] = 1;
                    if (lvl[i] == 6) t[6] = 1;
                    if (lvl[i] == 7) begin t[6] = 1; t[7] = 1; end
                end
            end
            m_tirq = t;
            for (int i = 0; i < NSRC; i++)
                np[i] = (m_pend[i] || req[i]) && !clr[i] &&
                        !(m_phase == P_WAIT && m_grant == i);
            case (m_phase)
                P_IDLE: if (rise) begin
                    w = pick();
                    if (w >= 0 && !blocked(lvl[w])) begin
                        m_grant = w;
                        m_vec = vecs[w];
                        m_phase = P_ARMED;
                    end
                end
                P_ARMED: begin
                    if (riaki) m_phase = P_VECTOR;
                    else if (fall) m_phase = P_IDLE;
                end
                P_VECTOR: m_phase = P_REPLY;
                P_REPLY: if (fall) m_phase = P_WAIT;
                default: begin
                    m_rr = (m_grant + 1) % NSRC;
                    m_phase = P_IDLE;
                end
            endcase
            for (int i = 0; i < NSRC; i++) m_pend[i] = np[i];
        end
    endtask

    // model advance and per-cycle comparison
    always @(posedge clk) begin
        logic [3:0] eack;
        model_step();
        #1;
        eack = (m_phase == P_WAIT) ? 4'(1 << m_grant) : 4'd0;
        chk("tirq", 32'(tirq), 32'(m_tirq));
        chk("trply", 32'(trply), 32'(m_phase == P_REPLY));
        chk("vector_en", 32'(ven),
            32'(m_phase == P_VECTOR || m_phase == P_REPLY));
        chk("src_ack", 32'(ack), 32'(eack));
        chk("tiako", 32'(tiako), 32'(riaki && m_phase == P_IDLE));
        if (m_phase == P_VECTOR || m_phase == P_REPLY)
            chk("vector_out", 32'(vout), 32'(m_vec));
        for (int i = 0; i < NSRC; i++)
            if (ack[i] === 1'b1) served.push_back(i);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_req(input logic [3:0] m);
        req = m;
        tick();
        req = '0;
    endtask

    task automatic wait_rply(input string nm);
        int n = 0;
        while (trply !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk(nm, 32'(trply), 32'd1);
    endtask

    task automatic intr_cycle(input logic [3:0] cmask, output logic [8:0] v);
        rdin = 1'b1;
        tick();
        riaki = 1'b1;
        clr = cmask;
        tick();
        clr = '0;
        wait_rply("rply_seen");
        v = vout;
        tick();
        rdin = 1'b0;
        riaki = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        logic [8:0] v;
        int base;
        int exp_ord[$];
        logic [8:0] exp_vec[$];

        rst_n = 1'b0; rinit = 1'b0; rdin = 1'b0; riaki = 1'b0;
        req = '0; clr = '0; rirq = '0;
        for (int i = 0; i < NSRC; i++) begin
            lvl[i] = 4;
            vecs[i] = '0;
            m_pend[i] = 0;
        end
        repeat (3) tick();
        chk("rst_tirq", 32'(tirq), 32'd0);
        chk("rst_trply", 32'(trply), 32'd0);
        chk("rst_ven", 32'(ven), 32'd0);
        chk("rst_vout", 32'(vout), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_tiako", 32'(tiako), 32'd0);
        rst_n = 1'b1;
        tick();

        // single source, level 5
        lvl[0] = 5;
        vecs[0] = 9'o270;
        base = served.size();
        pulse_req(4'b0001);
        tick();
        chk("single_tirq", 32'(tirq), 32'(4'b1100));
        intr_cycle(4'b0000, v);
        chk("single_vec", 32'(v), 32'(9'o270));
        chk("single_nack", served.size(), base + 1);
        if (served.size() == base + 1) chk("single_who", served[base], 0);
        tick();
        chk("single_tirq_clr", 32'(tirq), 32'd0);

        // level priority
        lvl[1] = 4; vecs[1] = 9'o100;
        lvl[2] = 6; vecs[2] = 9'o220;
        base = served.size();
        pulse_req(4'b0110);
        tick();
        chk("prio_tirq", 32'(tirq), 32'(4'b1010));
        intr_cycle(4'b0000, v);
        chk("prio_vec_a", 32'(v), 32'(9'o220));
        intr_cycle(4'b0000, v);
        chk("prio_vec_b", 32'(v), 32'(9'o100));
        chk("prio_nack", served.size(), base + 2);
        if (served.size() == base + 2) begin
            chk("prio_first", served[base], 2);
            chk("prio_second", served[base+1], 1);
        end

        // round-robin at level 5 with continuous requests
        rinit = 1'b1;
        tick();
        rinit = 1'b0;
        lvl[0] = 5; lvl[1] = 5; lvl[3] = 5;
        vecs[3] = 9'o330;
        base = served.size();
        req = 4'b1011;
        tick();
        tick();
        exp_ord = '{0, 1, 3, 0};
        exp_vec = '{9'o270, 9'o100, 9'o330, 9'o270};
        for (int r = 0; r < 4; r++) begin
            intr_cycle(4'b0000, v);
            chk("rr_vec", 32'(v), 32'(exp_vec[r]));
        end
        req = '0;
        chk("rr_nack", served.size(), base + 4);
        if (served.size() == base + 4)
            for (int r = 0; r < 4; r++)
                chk("rr_order", served[base+r], exp_ord[r]);
        rinit = 1'b1;
        tick();
        rinit = 1'b0;
        tick();

        // external block, then a data DIN
        lvl[1] = 4;
        base = served.size();
        rirq = 4'b0010;
        pulse_req(4'b0010);
        tick();
        rdin = 1'b1;
        riaki = 1'b1;
        tick();
        tick();
        chk("blk_tiako", 32'(tiako), 32'd1);
        chk("blk_trply", 32'(trply), 32'd0);
        rdin = 1'b0;
        riaki = 1'b0;
        rirq = 4'b0001;
        tick();
        tick();
        rdin = 1'b1;
        tick();
        tick();
        rdin = 1'b0;
        tick();
        tick();
        riaki = 1'b1;
        #1;
        chk("data_tiako", 32'(tiako), 32'd1);
        tick();
        riaki = 1'b0;
        chk("data_noack", served.size(), base);
        clr = 4'b0010;
        tick();
        clr = '0;
        rirq = '0;
        tick();

        // bus init in the middle of the reply
        base = served.size();
        pulse_req(4'b0110);
        tick();
        rdin = 1'b1;
        tick();
        riaki = 1'b1;
        tick();
        wait_rply("init_rply_seen");
        chk("init_pre_tirq", 32'(tirq), 32'(4'b1000));
        rinit = 1'b1;
        tick();
        rinit = 1'b0;
        chk("init_trply", 32'(trply), 32'd0);
        chk("init_ven", 32'(ven), 32'd0);
        chk("init_tirq", 32'(tirq), 32'd0);
        chk("init_ack", 32'(ack), 32'd0);
        tick();
        chk("init_pend_gone", 32'(tirq), 32'd0);
        riaki = 1'b0;
        rdin = 1'b0;
        tick();
        tick();
        chk("init_noack", served.size(), base);

        // request and cancel in the same cycle
        req = 4'b0001;
        clr = 4'b0001;
        tick();
        req = '0;
        clr = '0;
        tick();
        tick();
        chk("race_tirq", 32'(tirq), 32'd0);

        // cancel of the granted source while armed
        base = served.size();
        pulse_req(4'b0001);
        tick();
        intr_cycle(4'b0001, v);
        chk("gclr_vec", 32'(v), 32'(9'o270));
        chk("gclr_nack", served.size(), base + 1);
        if (served.size() == base + 1) chk("gclr_who", served[base], 0);
        tick();
        chk("gclr_tirq", 32'(tirq), 32'd0);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
